// File: rtl/fpu_issue_ctrl.sv
// Issue controller between the FPU top level and its add/mult/div units: decomposes a packed
// single-precision request, hands it to one unit, waits for a fresh result (or times out) and returns it.
module fpu_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [1:0]  op_i,
   input  logic [31:0] x_i,
   input  logic [31:0] y_i,
   input  logic [6:0]  rounding_mode_i,
   output logic [2:0]  unit_ready_o,
   output logic [6:0]  rounding_mode_o,
   output logic        x_sign_o,
   output logic        y_sign_o,
   output logic [7:0]  x_exp_o,
   output logic [7:0]  y_exp_o,
   output logic [22:0] x_frac_o,
   output logic [22:0] y_frac_o,
   output logic        x_greater_o,
   output logic [7:0]  exp_shift_o,
   output logic        x_infinity_o,
   output logic        y_infinity_o,
   output logic        x_nan_o,
   output logic        y_nan_o,
   input  logic [2:0]  unit_valid_i,
   input  logic [31:0] add_z_i,
   input  logic [31:0] mult_z_i,
   input  logic [31:0] div_z_i,
   input  logic [2:0]  unit_invalid_i,
   input  logic [2:0]  unit_overflow_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] z_o,
   output logic        except_invalid_operation_o,
   output logic        except_overflow_o,
   output logic        except_timeout_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_MULT = 2'd2;
   localparam logic [1:0] OP_DIV = 2'd3;
   localparam logic [31:0] TIMEOUT_Z = 32'h7FFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESPOND
   } state_t;

   state_t state, state_nxt;
   logic [1:0] op;
   logic seen_low;
   logic [CNT_W-1:0] timer;
   logic [2:0] target;
   logic tgt_valid;
   logic [31:0] tgt_z;
   logic capture;
   logic expire;

   function automatic logic [2:0] unit_onehot(input logic [1:0] o);
      case (o)
         OP_MULT: unit_onehot = 3'b010;
         OP_DIV:  unit_onehot = 3'b100;
         default: unit_onehot = 3'b001;
      endcase
   endfunction

   function automatic logic [7:0] exp_distance(input logic [7:0] a, input logic [7:0] b);
      logic signed [8:0] d;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      exp_distance = (d < 0) ? 8'(-d) : 8'(d);
   endfunction

   function automatic logic is_inf(input logic [31:0] v);
      is_inf = (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
   endfunction

   function automatic logic is_nan(input logic [31:0] v);
      is_nan = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
   endfunction

   assign target = unit_onehot(op);
   assign tgt_valid = |(unit_valid_i & target);

   always_comb begin
      tgt_z = add_z_i;
      case (target)
         3'b010:  tgt_z = mult_z_i;
         3'b100:  tgt_z = div_z_i;
         default: tgt_z = add_z_i;
      endcase
   end

   // A valid that was already high when the wait began belongs to the previous operation,
   // so a result is only taken once the target valid has been seen low at least once.
   assign capture = (state == WAIT) && tgt_valid && seen_low;
   assign expire = (state == WAIT) && !capture && (timer == CNT_W'(1));

   assign req_ready_o = (state == IDLE);
   assign rsp_valid_o = (state == RESPOND);
   assign unit_ready_o = (state == ISSUE) ? target : 3'b000;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid_i) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (capture || expire) state_nxt = RESPOND;
         RESPOND: if (rsp_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
         op <= 2'd0;
         seen_low <= 1'b0;
         timer <= '0;
         rounding_mode_o <= 7'd0;
         x_sign_o <= 1'b0;
         y_sign_o <= 1'b0;
         x_exp_o <= 8'd0;
         y_exp_o <= 8'd0;
         x_frac_o <= 23'd0;
         y_frac_o <= 23'd0;
         x_greater_o <= 1'b0;
         exp_shift_o <= 8'd0;
         x_infinity_o <= 1'b0;
         y_infinity_o <= 1'b0;
         x_nan_o <= 1'b0;
         y_nan_o <= 1'b0;
         z_o <= 32'd0;
         except_invalid_operation_o <= 1'b0;
         except_overflow_o <= 1'b0;
         except_timeout_o <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  op <= op_i;
                  rounding_mode_o <= rounding_mode_i;
                  x_sign_o <= x_i[31];
                  y_sign_o <= (op_i == OP_SUB) ? ~y_i[31] : y_i[31];
                  x_exp_o <= x_i[30:23];
                  y_exp_o <= y_i[30:23];
                  x_frac_o <= x_i[22:0];
                  y_frac_o <= y_i[22:0];
                  // magnitude compare on {exp,frac}, so the SUB sign flip cannot affect it
                  x_greater_o <= (x_i[30:0] > y_i[30:0]);
                  exp_shift_o <= exp_distance(x_i[30:23], y_i[30:23]);
                  x_infinity_o <= is_inf(x_i);
                  y_infinity_o <= is_inf(y_i);
                  x_nan_o <= is_nan(x_i);
                  y_nan_o <= is_nan(y_i);
               end
            end
            ISSUE: begin
               seen_low <= 1'b0;
               timer <= CNT_W'(TIMEOUT_CYCLES);
            end
            WAIT: begin
               timer <= timer - CNT_W'(1);
               if (!tgt_valid) seen_low <= 1'b1;
               if (capture) begin
                  z_o <= tgt_z;
                  except_invalid_operation_o <= |(unit_invalid_i & target);
                  except_overflow_o <= |(unit_overflow_i & target);
                  except_timeout_o <= 1'b0;
               end else if (expire) begin
                  z_o <= TIMEOUT_Z;
                  except_invalid_operation_o <= 1'b0;
                  except_overflow_o <= 1'b0;
                  except_timeout_o <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Randomised and directed bench for fpu_issue_ctrl, with a behavioural unit and host model.
module tb_fpu_issue_ctrl;

   localparam int T = 20;
   localparam int BUDGET = 3 * T + 100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  op_in;
   logic [31:0] x_in, y_in;
   logic [6:0]  rm_in;
   logic [2:0]  unit_ready;
   logic [6:0]  rm_out;
   logic        x_sign, y_sign;
   logic [7:0]  x_exp, y_exp;
   logic [22:0] x_frac, y_frac;
   logic        x_greater;
   logic [7:0]  exp_shift;
   logic        x_inf, y_inf, x_nan, y_nan;
   logic [2:0]  unit_valid;
   logic [31:0] add_z, mult_z, div_z;
   logic [2:0]  unit_inv, unit_ovf;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] z_out;
   logic        exc_inv, exc_ovf, exc_to;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fpu_issue_ctrl #(.TIMEOUT_CYCLES(T)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .op_i(op_in), .x_i(x_in), .y_i(y_in), .rounding_mode_i(rm_in),
      .unit_ready_o(unit_ready), .rounding_mode_o(rm_out),
      .x_sign_o(x_sign), .y_sign_o(y_sign), .x_exp_o(x_exp), .y_exp_o(y_exp),
      .x_frac_o(x_frac), .y_frac_o(y_frac), .x_greater_o(x_greater), .exp_shift_o(exp_shift),
      .x_infinity_o(x_inf), .y_infinity_o(y_inf), .x_nan_o(x_nan), .y_nan_o(y_nan),
      .unit_valid_i(unit_valid), .add_z_i(add_z), .mult_z_i(mult_z), .div_z_i(div_z),
      .unit_invalid_i(unit_inv), .unit_overflow_i(unit_ovf),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .z_o(z_out),
      .except_invalid_operation_o(exc_inv), .except_overflow_o(exc_ovf),
      .except_timeout_o(exc_to)
   );

   typedef struct packed {
      logic        xs;
      logic        ys;
      logic [7:0]  xe;
      logic [7:0]  ye;
      logic [22:0] xf;
      logic [22:0] yf;
      logic        gt;
      logic [7:0]  sh;
      logic        xi;
      logic        yi;
      logic        xn;
      logic        yn;
      logic [6:0]  rm;
   } dec_t;

   typedef struct {
      dec_t        dec;
      logic [2:0]  unit;
      int          pulses;
      int          rsp_k;
      logic [31:0] z;
      logic [2:0]  flags;
      bit          stable;
      bit          ignored_ok;
      bit          dropped_ok;
      bit          hung;
   } obs_t;

   dec_t live_dec;
   assign live_dec = {x_sign, y_sign, x_exp, y_exp, x_frac, y_frac, x_greater, exp_shift,
                      x_inf, y_inf, x_nan, y_nan, rm_out};

   wire [122:0] all_out = {unit_ready, rm_out, x_sign, y_sign, x_exp, y_exp, x_frac, y_frac,
                           x_greater, exp_shift, x_inf, y_inf, x_nan, y_nan, rsp_valid, z_out,
                           exc_inv, exc_ovf, exc_to};

   // Reference: what the IEEE fields of the request should look like once decomposed.
   function automatic dec_t model_dec(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                                      input logic [6:0] rm);
      dec_t d;
      int ex, ey, fx, fy, mx, my;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      fx = int'(x[22:0]);
      fy = int'(y[22:0]);
      mx = ex * (1 << 23) + fx;
      my = ey * (1 << 23) + fy;
      d.xs = x[31];
      d.ys = (op == 2'd1) ? ~y[31] : y[31];
      d.xe = x[30:23];
      d.ye = y[30:23];
      d.xf = x[22:0];
      d.yf = y[22:0];
      d.gt = (mx > my);
      d.sh = 8'((ex > ey) ? ex - ey : ey - ex);
      d.xi = (ex == 255) && (fx == 0);
      d.yi = (ey == 255) && (fy == 0);
      d.xn = (ex == 255) && (fx != 0);
      d.yn = (ey == 255) && (fy != 0);
      d.rm = rm;
      return d;
   endfunction

   function automatic logic [2:0] model_unit(input logic [1:0] op);
      if (op == 2'd3) return 3'b100;
      if (op == 2'd2) return 3'b010;
      return 3'b001;
   endfunction

   function automatic int unit_index(input logic [1:0] op);
      if (op == 2'd3) return 2;
      if (op == 2'd2) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 3))
         0: v[30:23] = 8'hFF;
         1: v[30:23] = 8'h00;
         2: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
         default: ;
      endcase
      return v;
   endfunction

   // One request: unit holds its old valid level for s wait cycles, drops it for l cycles, then
   // raises it with the result (unless never). The host then stalls the response for hold cycles.
   task automatic run_txn(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [6:0] rm, input int s, input int l, input bit never,
                          input logic [31:0] zv, input bit inv, input bit ovf, input int hold,
                          output obs_t o);
      int tgt, k;
      tgt = unit_index(op);
      o.pulses = 0; o.rsp_k = 0; o.z = '0; o.flags = '0; o.unit = '0; o.dec = '0;
      o.stable = 1'b1; o.ignored_ok = 1'b1; o.dropped_ok = 1'b1; o.hung = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; op_in = op; x_in = x; y_in = y; rm_in = rm;
      @(negedge clk);
      req_valid = 1'b0; op_in = 2'($urandom); x_in = $urandom; y_in = $urandom; rm_in = 7'($urandom);
      o.dec = live_dec;
      o.unit = unit_ready;
      if (unit_ready != 3'b000) o.pulses++;
      k = 0;
      while (!rsp_valid && k < BUDGET) begin
         for (int b = 0; b < 3; b++) begin
            if (b != tgt) begin
               unit_valid[b] = 1'($urandom);
               unit_inv[b] = 1'($urandom);
               unit_ovf[b] = 1'($urandom);
            end
         end
         if (tgt != 0) add_z = $urandom;
         if (tgt != 1) mult_z = $urandom;
         if (tgt != 2) div_z = $urandom;
         if (!never && k > s && k <= s + l) unit_valid[tgt] = 1'b0;
         if (!never && k > s + l) begin
            unit_valid[tgt] = 1'b1;
            unit_inv[tgt] = inv;
            unit_ovf[tgt] = ovf;
            if (tgt == 0) add_z = zv;
            else if (tgt == 1) mult_z = zv;
            else div_z = zv;
         end
         @(negedge clk);
         k++;
         if (unit_ready != 3'b000) o.pulses++;
         if (live_dec !== o.dec) o.stable = 1'b0;
      end
      if (!rsp_valid) begin
         o.hung = 1'b1;
         return;
      end
      o.rsp_k = k;
      o.z = z_out;
      o.flags = {exc_inv, exc_ovf, exc_to};
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1; op_in = 2'($urandom); x_in = $urandom; y_in = $urandom;
         @(negedge clk);
         if (!rsp_valid || z_out !== o.z || {exc_inv, exc_ovf, exc_to} !== o.flags ||
             live_dec !== o.dec) o.stable = 1'b0;
         if (req_ready) o.ignored_ok = 1'b0;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      o.dropped_ok = !rsp_valid && req_ready;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_total++;
      if (all_out !== '0) $display("FAIL reset_outputs got %h want 0", all_out);
      else n_pass++;
      n_total++;
      if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready);
      else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
      n_total++;
      if ({req_ready, rsp_valid, unit_ready} !== 5'b10000)
         $display("FAIL post_reset_idle got %b want 10000", {req_ready, rsp_valid, unit_ready});
      else n_pass++;
   endtask

   task automatic test_add();
      obs_t o;
      run_txn(2'd0, 32'h3F80_0000, 32'h4000_0000, 7'h05, 0, 2, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 0, o);
      n_total++;
      if (o.unit !== 3'b001 || o.pulses !== 1)
         $display("FAIL add_issue got unit=%b pulses=%0d want 001/1", o.unit, o.pulses);
      else n_pass++;
      n_total++;
      if (o.z !== 32'h4040_0000 || o.flags !== 3'b000)
         $display("FAIL add_result got %h/%b want 40400000/000", o.z, o.flags);
      else n_pass++;
      n_total++;
      if (o.rsp_k !== 4) $display("FAIL add_latency got %0d want 4", o.rsp_k);
      else n_pass++;
   endtask

   task automatic test_sub();
      obs_t o;
      run_txn(2'd1, 32'h4040_0000, 32'h3F80_0000, 7'h11, 1, 1, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 0, o);
      n_total++;
      if ({o.dec.ys, o.dec.gt, o.dec.sh} !== {1'b1, 1'b1, 8'd1})
         $display("FAIL sub_fields got ys=%b gt=%b sh=%0d want 1/1/1", o.dec.ys, o.dec.gt, o.dec.sh);
      else n_pass++;
      n_total++;
      if (o.unit !== 3'b001 || o.z !== 32'h4000_0000)
         $display("FAIL sub_route got unit=%b z=%h want 001/40000000", o.unit, o.z);
      else n_pass++;
   endtask

   task automatic test_equal_mag();
      obs_t o;
      run_txn(2'd0, 32'hC120_0000, 32'h4120_0000, 7'h00, 0, 1, 1'b0, 32'h0, 1'b0, 1'b0, 0, o);
      n_total++;
      if ({o.dec.gt, o.dec.sh} !== 9'd0)
         $display("FAIL equal_mag got gt=%b sh=%0d want 0/0", o.dec.gt, o.dec.sh);
      else n_pass++;
   endtask

   task automatic test_div_stale();
      obs_t o;
      unit_valid[2] = 1'b1;
      div_z = 32'h1234_5678;
      run_txn(2'd3, 32'h40C0_0000, 32'h0000_0000, 7'h02, 3, 2, 1'b0, 32'h7F80_0000, 1'b1, 1'b0, 0, o);
      n_total++;
      if (o.rsp_k !== 7) $display("FAIL div_stale_latency got %0d want 7", o.rsp_k);
      else n_pass++;
      n_total++;
      if (o.z !== 32'h7F80_0000 || o.flags !== 3'b100 || o.unit !== 3'b100)
         $display("FAIL div_result got %h/%b/%b want 7f800000/100/100", o.z, o.flags, o.unit);
      else n_pass++;
   endtask

   task automatic test_timeout();
      obs_t o;
      unit_valid[1] = 1'b0;
      run_txn(2'd2, 32'h4000_0000, 32'h4000_0000, 7'h00, 0, 1, 1'b1, 32'h0, 1'b0, 1'b0, 0, o);
      n_total++;
      if (o.hung || o.rsp_k !== T + 1) $display("FAIL timeout_latency got %0d want %0d", o.rsp_k, T + 1);
      else n_pass++;
      n_total++;
      if (o.z !== 32'h7FFF_FFFF || o.flags !== 3'b001)
         $display("FAIL timeout_result got %h/%b want 7fffffff/001", o.z, o.flags);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      obs_t o;
      run_txn(2'd2, 32'h4100_0000, 32'h3F00_0000, 7'h3C, 0, 3, 1'b0, 32'h4080_0000, 1'b0, 1'b1, 10, o);
      n_total++;
      if (!o.stable) $display("FAIL backpressure_stable got unstable want stable");
      else n_pass++;
      n_total++;
      if (!o.ignored_ok) $display("FAIL backpressure_req_ready got 1 want 0");
      else n_pass++;
      n_total++;
      if (!o.dropped_ok) $display("FAIL backpressure_release got rsp_valid still high want 0");
      else n_pass++;
      n_total++;
      if (o.z !== 32'h4080_0000 || o.flags !== 3'b010)
         $display("FAIL backpressure_result got %h/%b want 40800000/010", o.z, o.flags);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      obs_t o;
      bit quiet;
      @(negedge clk);
      req_valid = 1'b1; op_in = 2'd2; x_in = 32'h4000_0000; y_in = 32'h4040_0000; rm_in = 7'h7F;
      @(negedge clk);
      req_valid = 1'b0;
      unit_valid[1] = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_total++;
      if (all_out !== '0 || req_ready !== 1'b1)
         $display("FAIL mid_reset_outputs got %h ready=%b want 0/1", all_out, req_ready);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      unit_valid[1] = 1'b1;
      mult_z = 32'hDEAD_BEEF;
      quiet = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (rsp_valid || !req_ready || z_out !== 32'd0) quiet = 1'b0;
      end
      n_total++;
      if (!quiet) $display("FAIL late_valid_ignored got rsp_valid=%b z=%h want 0/0", rsp_valid, z_out);
      else n_pass++;
      run_txn(2'd0, 32'h3F80_0000, 32'h3F80_0000, 7'h01, 0, 2, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 0, o);
      n_total++;
      if (o.z !== 32'h4000_0000 || o.flags !== 3'b000 || o.rsp_k !== 4)
         $display("FAIL after_reset_add got %h/%b/%0d want 40000000/000/4", o.z, o.flags, o.rsp_k);
      else n_pass++;
   endtask

   task automatic test_random(input int n);
      obs_t o;
      for (int i = 0; i < n; i++) begin
         logic [1:0] op;
         logic [31:0] x, y, zv;
         logic [6:0] rm;
         int s, l, hold, exp_k;
         bit never, inv, ovf, to;
         logic [31:0] exp_z;
         logic [2:0] exp_flags;
         op = 2'($urandom_range(0, 3));
         x = rand_fp();
         y = ($urandom_range(0, 3) == 0) ? {1'($urandom), x[30:0]} : rand_fp();
         rm = 7'($urandom);
         zv = $urandom;
         inv = 1'($urandom);
         ovf = 1'($urandom);
         s = $urandom_range(0, 3);
         l = ($urandom_range(0, 7) == 0) ? T : $urandom_range(1, 6);
         never = ($urandom_range(0, 9) == 0);
         hold = $urandom_range(0, 3);
         run_txn(op, x, y, rm, s, l, never, zv, inv, ovf, hold, o);
         to = never || (s + l + 1 > T);
         exp_k = to ? T + 1 : s + l + 2;
         exp_z = to ? 32'h7FFF_FFFF : zv;
         exp_flags = to ? 3'b001 : {inv, ovf, 1'b0};
         n_total++;
         if (o.dec !== model_dec(op, x, y, rm) || o.unit !== model_unit(op) || o.pulses !== 1)
            $display("FAIL rand_issue[%0d] got %h/%b/%0d want %h/%b/1", i, o.dec, o.unit, o.pulses,
                     model_dec(op, x, y, rm), model_unit(op));
         else n_pass++;
         n_total++;
         if (o.hung || o.rsp_k !== exp_k || o.z !== exp_z || o.flags !== exp_flags)
            $display("FAIL rand_rsp[%0d] got k=%0d z=%h f=%b want k=%0d z=%h f=%b", i, o.rsp_k,
                     o.z, o.flags, exp_k, exp_z, exp_flags);
         else n_pass++;
         n_total++;
         if (!o.stable || !o.ignored_ok || !o.dropped_ok)
            $display("FAIL rand_hold[%0d] got stable=%b ignored=%b dropped=%b want 1/1/1", i,
                     o.stable, o.ignored_ok, o.dropped_ok);
         else n_pass++;
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; op_in = '0; x_in = '0; y_in = '0; rm_in = '0;
      unit_valid = '0; add_z = '0; mult_z = '0; div_z = '0; unit_inv = '0; unit_ovf = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_equal_mag();
      test_div_stale();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      test_random(40);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
